// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: line geometry, fill-FIFO entry format
// and the line deserializer FSM states.
package cc_pkg;

   localparam int unsigned LINE_W   = 512;
   localparam int unsigned BEAT_W   = 64;
   localparam int unsigned BEATS    = 8;
   localparam int unsigned OFFSET_W = 6;
   localparam int unsigned FIFO_W   = OFFSET_W + LINE_W;
   localparam int unsigned IDX_W    = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PUSH = 2'd2
   } deser_state_e;

   // Fill-FIFO entry, identical to what the serializer consumes
   typedef struct packed {
      logic [OFFSET_W-1:0] offset;
      logic [LINE_W-1:0]   line;
   } fifo_entry_t;

   // Line slot for the cnt-th beat of a critical-word-first wrapping burst
   function automatic logic [IDX_W-1:0] beat_slot(input logic [OFFSET_W-1:0] off,
                                                  input logic [IDX_W-1:0]    cnt);
      return IDX_W'(off[OFFSET_W-1:3] + cnt);
   endfunction

endpackage

// File: rtl/cc_line_deserializer_if.sv
// Request, memory read channel and fill-FIFO signals of the line deserializer.
interface cc_line_deserializer_if;
   import cc_pkg::*;

   logic                req_valid_i;
   logic [OFFSET_W-1:0] req_offset_i;
   logic                req_ready_o;
   logic [BEAT_W-1:0]   mem_rdata_i;
   logic                mem_rlast_i;
   logic                mem_rvalid_i;
   logic                mem_rready_o;
   logic                fifo_full_i;
   logic                fifo_wren_o;
   fifo_entry_t         fifo_wdata_o;
   logic                err_o;

   modport slave (
      input  req_valid_i, req_offset_i, mem_rdata_i, mem_rlast_i, mem_rvalid_i, fifo_full_i,
      output req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, err_o
   );

   modport master (
      output req_valid_i, req_offset_i, mem_rdata_i, mem_rlast_i, mem_rvalid_i, fifo_full_i,
      input  req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, err_o
   );

endinterface

// File: rtl/cc_line_buf.sv
// Eight-beat line buffer: indexed beat writes, whole line read flat.
module cc_line_buf
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [BEAT_W-1:0] wr_data_i,
   output logic [LINE_W-1:0] line_o
);

   logic [BEAT_W-1:0] mem_q [BEATS];

   // Beat storage; slots keep their contents until the next fill overwrites them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BEATS; i++) mem_q[i] <= '0;
      end else if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   for (genvar g = 0; g < BEATS; g++) begin : g_flat
      assign line_o[g*BEAT_W +: BEAT_W] = mem_q[g];
   end

endmodule

// File: rtl/cc_line_deserializer.sv
// Reassembles a critical-word-first 8-beat read burst into a natural-order
// cache line and writes {offset, line} into the fill FIFO.
// Optional rlast protocol checking is built when CC_DESER_RLAST_CHK_EN is defined.
module cc_line_deserializer
   import cc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   cc_line_deserializer_if.slave bus
);

   deser_state_e        state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [OFFSET_W-1:0] off_q, off_d;
   logic                req_ready_q, req_ready_d;
   logic                mem_rready_q, mem_rready_d;
   logic                fifo_wren_c;
   logic                beat_acc_c;
   logic [LINE_W-1:0]   line_c;
   logic [FIFO_W-1:0]   entry_c;

   assign beat_acc_c = mem_rready_q & bus.mem_rvalid_i;

   // Next state, beat counter, offset capture and FIFO write strobe
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      fifo_wren_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               off_d   = bus.req_offset_i;
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (beat_acc_c) begin
               cnt_d = IDX_W'(cnt_q + 1'b1);
               if (cnt_q == IDX_W'(BEATS - 1)) state_d = PUSH;
            end
         end
         PUSH: begin
            fifo_wren_c = ~bus.fifo_full_i;
            if (!bus.fifo_full_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d  = (state_d == IDLE);
      mem_rready_d = (state_d == FILL);
   end

   // State and handshake registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         off_q        <= '0;
         req_ready_q  <= 1'b1;
         mem_rready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         off_q        <= off_d;
         req_ready_q  <= req_ready_d;
         mem_rready_q <= mem_rready_d;
      end
   end

   cc_line_buf u_line_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (beat_acc_c),
      .wr_idx_i  (beat_slot(off_q, cnt_q)),
      .wr_data_i (bus.mem_rdata_i),
      .line_o    (line_c)
   );

   assign entry_c          = {off_q, line_c};
   assign bus.fifo_wdata_o = entry_c;
   assign bus.fifo_wren_o  = fifo_wren_c;
   assign bus.req_ready_o  = req_ready_q;
   assign bus.mem_rready_o = mem_rready_q;

`ifdef CC_DESER_RLAST_CHK_EN
   logic err_q, err_d;

   // Sticky flag: rlast must be set on the eighth accepted beat and only there
   always_comb begin
      err_d = err_q;
      if (beat_acc_c && (bus.mem_rlast_i != (cnt_q == IDX_W'(BEATS - 1)))) err_d = 1'b1;
   end

   // Error register, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   logic unused_rlast;
   assign unused_rlast = bus.mem_rlast_i;
   assign bus.err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cc_line_deserializer.sv
// Randomized self-checking bench for cc_line_deserializer against a
// slot-array reference model of the wrapping burst reassembly.
`timescale 1ns/1ps
module tb_cc_line_deserializer;
   import cc_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cc_line_deserializer_if bus();

   cc_line_deserializer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef CC_DESER_RLAST_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: line slots, sticky error, beats of the current burst
   logic [63:0] beats    [8];
   logic [63:0] ref_line [8];
   bit          ref_err;

   // Observations from the last fill
   int          cyc;
   int          beat_cyc [8];
   int          wr_cyc;
   int          wr_cnt;
   int          viol;
   int          err_cyc;
   bit          timeout;
   fifo_entry_t wr_data;

   function automatic fifo_entry_t ref_entry(input logic [5:0] off);
      fifo_entry_t e;
      e.offset = off;
      for (int s = 0; s < 8; s++) e.line[s*64 +: 64] = ref_line[s];
      return e;
   endfunction

   task automatic ref_fill(input logic [5:0] off, input int rlast_at);
      int crit = int'(off) / 8;
      for (int k = 0; k < 8; k++) ref_line[(crit + k) % 8] = beats[k];
      if (CHK_EN && rlast_at != 8) ref_err = 1'b1;
   endtask

   task automatic ref_reset();
      for (int s = 0; s < 8; s++) ref_line[s] = '0;
      ref_err = 1'b0;
   endtask

   task automatic rand_beats();
      for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.fifo_full_i = 1'b0; bus.mem_rlast_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ref_reset();
   endtask

   // One request plus burst; gap_mode 0 = dense, 1 = every other cycle, 2 = random.
   // Cycle 0 is the request cycle.
   task automatic run_fill(input logic [5:0] off, input int gap_mode, input int full_cyc,
                           input int rlast_at);
      int          k = 0;
      int          guard = 0;
      bit          v;
      fifo_entry_t held;
      viol = 0; wr_cyc = -1; wr_cnt = 0; err_cyc = -1; timeout = 1'b0; cyc = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_offset_i = off;
      bus.mem_rvalid_i = 1'b0; bus.mem_rlast_i = 1'b0; bus.fifo_full_i = 1'b0;
      #1;
      if (bus.req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0 || bus.fifo_wren_o !== 1'b0) viol++;
      if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
      while (k < 8 && !timeout) begin
         @(negedge clk); cyc++; guard++;
         bus.req_valid_i  = 1'($urandom);
         bus.req_offset_i = 6'($urandom);
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 1;
            default: v = 1'($urandom);
         endcase
         bus.mem_rvalid_i = v;
         bus.mem_rdata_i  = v ? beats[k] : {$urandom, $urandom};
         bus.mem_rlast_i  = v && (k + 1 == rlast_at);
         #1;
         if (bus.mem_rready_o !== 1'b1 || bus.req_ready_o !== 1'b0 || bus.fifo_wren_o !== 1'b0) viol++;
         if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
         if (v) begin beat_cyc[k] = cyc; k++; end
         if (guard > 200) timeout = 1'b1;
      end
      for (int i = 0; i <= full_cyc && !timeout; i++) begin
         @(negedge clk); cyc++;
         bus.req_valid_i  = 1'b0;
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = {$urandom, $urandom};
         bus.mem_rlast_i  = 1'($urandom);
         bus.fifo_full_i  = (i < full_cyc);
         #1;
         if (bus.mem_rready_o !== 1'b0 || bus.req_ready_o !== 1'b0) viol++;
         if (i == 0) held = bus.fifo_wdata_o;
         else if (bus.fifo_wdata_o !== held) viol++;
         if (bus.fifo_full_i && bus.fifo_wren_o !== 1'b0) viol++;
         if (bus.fifo_wren_o === 1'b1) begin wr_cnt++; wr_cyc = cyc; wr_data = bus.fifo_wdata_o; end
         if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
      end
      @(negedge clk); cyc++;
      bus.mem_rvalid_i = 1'b0; bus.fifo_full_i = 1'b0; bus.mem_rlast_i = 1'b0;
      #1;
      if (bus.req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0 || bus.fifo_wren_o !== 1'b0) viol++;
      if (bus.err_o === 1'b1 && err_cyc < 0) err_cyc = cyc;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      #1;
      n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready_o); end
      n_checks++; if (bus.mem_rready_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rready: got %b expected 0", bus.mem_rready_o); end
      n_checks++; if (bus.fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b expected 0", bus.fifo_wren_o); end
      n_checks++; if (bus.fifo_wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus.fifo_wdata_o); end
      n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_aligned();
      for (int k = 0; k < 8; k++) beats[k] = {16{4'(k)}};
      run_fill(6'd0, 0, 0, 8);
      ref_fill(6'd0, 8);
      n_checks++; if (timeout || viol != 0) begin n_fail++; $display("FAIL aligned_protocol: got timeout=%0d viol=%0d expected 0/0", timeout, viol); end
      n_checks++; if (wr_cnt != 1 || wr_cyc != 9) begin n_fail++; $display("FAIL aligned_write_cycle: got cnt=%0d cyc=%0d expected 1/9", wr_cnt, wr_cyc); end
      n_checks++; if (wr_data.line[63:0] !== 64'h0) begin n_fail++; $display("FAIL aligned_beat0: got %h expected 0", wr_data.line[63:0]); end
      n_checks++; if (wr_data.line[511:448] !== 64'h7777777777777777) begin n_fail++; $display("FAIL aligned_beat7: got %h expected 7777777777777777", wr_data.line[511:448]); end
      n_checks++; if (wr_data !== ref_entry(6'd0)) begin n_fail++; $display("FAIL aligned_entry: got %h expected %h", wr_data, ref_entry(6'd0)); end
      n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL aligned_err: got %b expected 0", bus.err_o); end
   endtask

   task automatic test_wrapped();
      rand_beats();
      run_fill(6'd16, 0, 0, 8);
      ref_fill(6'd16, 8);
      n_checks++; if (timeout || viol != 0 || wr_cyc != 9) begin n_fail++; $display("FAIL wrapped_protocol: got timeout=%0d viol=%0d cyc=%0d expected 0/0/9", timeout, viol, wr_cyc); end
      n_checks++; if (wr_data.line[2*64 +: 64] !== beats[0]) begin n_fail++; $display("FAIL wrapped_slot2: got %h expected %h", wr_data.line[2*64 +: 64], beats[0]); end
      n_checks++; if (wr_data.line[7*64 +: 64] !== beats[5]) begin n_fail++; $display("FAIL wrapped_slot7: got %h expected %h", wr_data.line[7*64 +: 64], beats[5]); end
      n_checks++; if (wr_data.line[0 +: 64] !== beats[6]) begin n_fail++; $display("FAIL wrapped_slot0: got %h expected %h", wr_data.line[0 +: 64], beats[6]); end
      n_checks++; if (wr_data.line[64 +: 64] !== beats[7]) begin n_fail++; $display("FAIL wrapped_slot1: got %h expected %h", wr_data.line[64 +: 64], beats[7]); end
      n_checks++; if (wr_data.offset !== 6'd16) begin n_fail++; $display("FAIL wrapped_offset: got %0d expected 16", wr_data.offset); end
      n_checks++; if (wr_data !== ref_entry(6'd16)) begin n_fail++; $display("FAIL wrapped_entry: got %h expected %h", wr_data, ref_entry(6'd16)); end
   endtask

   task automatic test_backpressure();
      logic [5:0] off = 6'($urandom);
      rand_beats();
      run_fill(off, 0, 5, 8);
      ref_fill(off, 8);
      n_checks++; if (timeout || viol != 0) begin n_fail++; $display("FAIL bp_protocol: got timeout=%0d viol=%0d expected 0/0", timeout, viol); end
      n_checks++; if (wr_cnt != 1 || wr_cyc != 14) begin n_fail++; $display("FAIL bp_write_cycle: got cnt=%0d cyc=%0d expected 1/14", wr_cnt, wr_cyc); end
      n_checks++; if (wr_data !== ref_entry(off)) begin n_fail++; $display("FAIL bp_entry: got %h expected %h", wr_data, ref_entry(off)); end
   endtask

   task automatic test_rvalid_gaps();
      logic [5:0] off = 6'($urandom);
      rand_beats();
      run_fill(off, 1, 0, 8);
      ref_fill(off, 8);
      n_checks++; if (timeout || viol != 0) begin n_fail++; $display("FAIL gaps_protocol: got timeout=%0d viol=%0d expected 0/0", timeout, viol); end
      n_checks++; if (beat_cyc[7] != 15 || wr_cyc != beat_cyc[7] + 1) begin n_fail++; $display("FAIL gaps_write_cycle: got last_beat=%0d wr=%0d expected 15/16", beat_cyc[7], wr_cyc); end
      n_checks++; if (wr_data !== ref_entry(off)) begin n_fail++; $display("FAIL gaps_entry: got %h expected %h", wr_data, ref_entry(off)); end
   endtask

   task automatic test_random_fills();
      for (int n = 0; n < 6; n++) begin
         logic [5:0] off = 6'($urandom);
         int         full = int'($urandom_range(0, 3));
         rand_beats();
         run_fill(off, 2, full, 8);
         ref_fill(off, 8);
         n_checks++; if (timeout || viol != 0 || wr_cnt != 1) begin n_fail++; $display("FAIL random_protocol[%0d]: got timeout=%0d viol=%0d writes=%0d expected 0/0/1", n, timeout, viol, wr_cnt); end
         n_checks++; if (wr_cyc != beat_cyc[7] + 1 + full) begin n_fail++; $display("FAIL random_write_cycle[%0d]: got %0d expected %0d", n, wr_cyc, beat_cyc[7] + 1 + full); end
         n_checks++; if (wr_data !== ref_entry(off)) begin n_fail++; $display("FAIL random_entry[%0d]: got %h expected %h", n, wr_data, ref_entry(off)); end
      end
   endtask

   task automatic test_rlast_early();
      logic [5:0] off = 6'($urandom);
      int         exp_cyc = CHK_EN ? 4 : -1;
      rand_beats();
      run_fill(off, 0, 0, 3);
      ref_fill(off, 3);
      n_checks++; if (err_cyc != exp_cyc) begin n_fail++; $display("FAIL rlast_early_err_cycle: got %0d expected %0d", err_cyc, exp_cyc); end
      n_checks++; if (bus.err_o !== ref_err) begin n_fail++; $display("FAIL rlast_early_err: got %b expected %b", bus.err_o, ref_err); end
      n_checks++; if (viol != 0 || wr_cyc != 9 || wr_data !== ref_entry(off)) begin n_fail++; $display("FAIL rlast_early_write: got viol=%0d cyc=%0d data=%h expected 0/9/%h", viol, wr_cyc, wr_data, ref_entry(off)); end
   endtask

   task automatic test_rlast_missing();
      logic [5:0] off = 6'($urandom);
      int         exp_cyc = CHK_EN ? 9 : -1;
      apply_reset();
      rand_beats();
      run_fill(off, 0, 0, 0);
      ref_fill(off, 0);
      n_checks++; if (err_cyc != exp_cyc) begin n_fail++; $display("FAIL rlast_missing_err_cycle: got %0d expected %0d", err_cyc, exp_cyc); end
      n_checks++; if (bus.err_o !== ref_err) begin n_fail++; $display("FAIL rlast_missing_err: got %b expected %b", bus.err_o, ref_err); end
      n_checks++; if (viol != 0 || wr_data !== ref_entry(off)) begin n_fail++; $display("FAIL rlast_missing_write: got viol=%0d data=%h expected 0/%h", viol, wr_data, ref_entry(off)); end
   endtask

   task automatic test_reset_mid_burst();
      int writes = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_offset_i = 6'd24; bus.fifo_full_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.req_valid_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rlast_i = 1'b0;
         bus.mem_rdata_i = {$urandom, $urandom};
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (bus.req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got req=%b mem=%b expected 1/0", bus.req_ready_o, bus.mem_rready_o); end
      n_checks++; if (bus.fifo_wren_o !== 1'b0 || bus.fifo_wdata_o !== '0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got wren=%b err=%b wdata=%h expected 0/0/0", bus.fifo_wren_o, bus.err_o, bus.fifo_wdata_o); end
      @(negedge clk);
      rst = 1'b0; bus.mem_rvalid_i = 1'b0;
      ref_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); #1;
         if (bus.fifo_wren_o === 1'b1) writes++;
      end
      n_checks++; if (writes != 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected 0", writes); end
      rand_beats();
      run_fill(6'd56, 0, 0, 8);
      ref_fill(6'd56, 8);
      n_checks++; if (timeout || viol != 0 || wr_cyc != 9) begin n_fail++; $display("FAIL midrst_refill_protocol: got timeout=%0d viol=%0d cyc=%0d expected 0/0/9", timeout, viol, wr_cyc); end
      n_checks++; if (wr_data !== ref_entry(6'd56)) begin n_fail++; $display("FAIL midrst_refill_entry: got %h expected %h", wr_data, ref_entry(6'd56)); end
      n_checks++; if (wr_data.line[7*64 +: 64] !== beats[0] || wr_data.line[0 +: 64] !== beats[1]) begin n_fail++; $display("FAIL midrst_refill_wrap: got s7=%h s0=%h expected %h/%h", wr_data.line[7*64 +: 64], wr_data.line[0 +: 64], beats[0], beats[1]); end
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid_i  = 1'b0;
      bus.req_offset_i = '0;
      bus.mem_rdata_i  = '0;
      bus.mem_rlast_i  = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.fifo_full_i  = 1'b0;
      ref_reset();
      test_reset();
      test_aligned();
      test_wrapped();
      test_backpressure();
      test_rvalid_gaps();
      test_random_fills();
      test_rlast_early();
      test_rlast_missing();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
